// File: rtl/bist_pkg.sv
// Shared types and default configuration values for the LFSR/MISR self-test controller.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_SETTLE,
    ST_COMPARE,
    ST_DONE
  } bist_state_e;

  // Default run configurations; override per characterised LFSR/MISR pair.
  localparam logic [3:0]  LFSR_POLY_4      = 4'b1001;
  localparam logic [3:0]  GOLDEN_SIG_4     = 4'hA;
  localparam int          PATTERN_COUNT_4  = 15;

  localparam logic [15:0] LFSR_POLY_16     = 16'b1011_0100_0000_0001;
  localparam logic [15:0] GOLDEN_SIG_16    = 16'h5A3C;
  localparam int          PATTERN_COUNT_16 = 1024;

endpackage

// File: rtl/bist_pattern_cnt.sv
// Saturating pattern counter with synchronous clear; tc flags that the next
// enabled cycle brings the count to TERM.
module bist_pattern_cnt #(
  parameter int CNT_WIDTH = 16,
  parameter int TERM      = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 tc
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] TERM_M1 = (TERM > 0) ? CNT_WIDTH'(TERM - 1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt <= '0;
    else if (clr)                    cnt <= '0;
    else if (en && cnt != CNT_MAX)   cnt <= cnt + CNT_WIDTH'(1);
  end

  assign tc = (cnt == TERM_M1);

endmodule

// File: rtl/bist_ctrl.sv
// Self-test sequencer: seed reload, PATTERN_COUNT enabled cycles, settle, signature compare.
// Define BIST_SIG_CAPTURE_EN to add the sig_out diagnostic capture register.
module bist_ctrl
  import bist_pkg::*;
#(
  parameter int                     LFSR_LENGTH   = 4,
  parameter int                     CNT_WIDTH     = 16,
  parameter int                     PATTERN_COUNT = 15,
  parameter logic [LFSR_LENGTH-1:0] GOLDEN_SIG    = LFSR_LENGTH'(4'hA)
) (
  input  logic                   lfsr_clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   abort,
  output logic                   seed_load,
  output logic                   lfsr_en,
  output logic                   misr_en,
  input  logic [LFSR_LENGTH-1:0] misr_state_in,
  output logic [CNT_WIDTH-1:0]   pattern_cnt,
`ifdef BIST_SIG_CAPTURE_EN
  output logic [LFSR_LENGTH-1:0] sig_out,
`endif
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   fail
);

  localparam logic HAS_PATTERNS = (PATTERN_COUNT > 0);

  if (PATTERN_COUNT < 0 || (PATTERN_COUNT >> CNT_WIDTH) != 0) begin : g_cnt_range
    $error("bist_ctrl: PATTERN_COUNT does not fit in CNT_WIDTH");
  end

  bist_state_e state;
  logic        cnt_clr, cnt_en, cnt_tc;

  // Counter clears on the edge that enters LOAD, so LOAD already shows zero.
  assign cnt_clr = (state == ST_IDLE || state == ST_DONE) && start && !abort;
  assign cnt_en  = (state == ST_RUN);

  bist_pattern_cnt #(
    .CNT_WIDTH (CNT_WIDTH),
    .TERM      (PATTERN_COUNT)
  ) u_cnt (
    .clk   (lfsr_clk),
    .rst_n (resetn),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (pattern_cnt),
    .tc    (cnt_tc)
  );

  always_ff @(posedge lfsr_clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      seed_load <= 1'b0;
      lfsr_en   <= 1'b0;
      misr_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
`ifdef BIST_SIG_CAPTURE_EN
      sig_out   <= '0;
`endif
    end else if (abort) begin
      state     <= ST_IDLE;
      seed_load <= 1'b0;
      lfsr_en   <= 1'b0;
      misr_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_LOAD;
            seed_load <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
          end
        end
        ST_LOAD: begin
          seed_load <= 1'b0;
          if (HAS_PATTERNS) begin
            state   <= ST_RUN;
            lfsr_en <= 1'b1;
            misr_en <= 1'b1;
          end else begin
            state   <= ST_SETTLE;
          end
        end
        ST_RUN: begin
          if (cnt_tc) begin
            state   <= ST_SETTLE;
            lfsr_en <= 1'b0;
            misr_en <= 1'b0;
          end
        end
        ST_SETTLE: state <= ST_COMPARE;
        ST_COMPARE: begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (misr_state_in == GOLDEN_SIG);
          fail  <= (misr_state_in != GOLDEN_SIG);
`ifdef BIST_SIG_CAPTURE_EN
          sig_out <= misr_state_in;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_ctrl.sv
// Directed bench for bist_ctrl: a 15-pattern instance and a zero-pattern instance.
module tb_bist_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic        start0 = 1'b0, abort0 = 1'b0;
  logic [3:0]  misr = 4'h0;

  logic        seed_load, lfsr_en, misr_en, busy, done, pass, fail;
  logic [15:0] pattern_cnt;
  logic        seed_load0, lfsr_en0, misr_en0, busy0, done0, pass0, fail0;
  logic [15:0] pattern_cnt0;
`ifdef BIST_SIG_CAPTURE_EN
  logic [3:0]  sig_out, sig_out0;
`endif

  int total = 0;
  int bad   = 0;

  wire [6:0] flags  = {seed_load,  lfsr_en,  misr_en,  busy,  done,  pass,  fail};
  wire [6:0] flags0 = {seed_load0, lfsr_en0, misr_en0, busy0, done0, pass0, fail0};

  always #5 clk = ~clk;

  bist_ctrl #(.LFSR_LENGTH(4), .CNT_WIDTH(16), .PATTERN_COUNT(15), .GOLDEN_SIG(4'hA)) dut (
    .lfsr_clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .seed_load(seed_load), .lfsr_en(lfsr_en), .misr_en(misr_en),
    .misr_state_in(misr), .pattern_cnt(pattern_cnt),
`ifdef BIST_SIG_CAPTURE_EN
    .sig_out(sig_out),
`endif
    .busy(busy), .done(done), .pass(pass), .fail(fail)
  );

  bist_ctrl #(.LFSR_LENGTH(4), .CNT_WIDTH(16), .PATTERN_COUNT(0), .GOLDEN_SIG(4'hA)) dut0 (
    .lfsr_clk(clk), .resetn(resetn), .start(start0), .abort(abort0),
    .seed_load(seed_load0), .lfsr_en(lfsr_en0), .misr_en(misr_en0),
    .misr_state_in(misr), .pattern_cnt(pattern_cnt0),
`ifdef BIST_SIG_CAPTURE_EN
    .sig_out(sig_out0),
`endif
    .busy(busy0), .done(done0), .pass(pass0), .fail(fail0)
  );

  // flags order: seed_load lfsr_en misr_en busy done pass fail
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (2) tick();
    total++;
    if (flags !== 7'b0 || pattern_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_hold flags=%b cnt=%0d want 0", flags, pattern_cnt);
    end
    #2 resetn = 1'b1;
    tick(); tick();
    total++;
    if (flags !== 7'b0 || pattern_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_release flags=%b cnt=%0d want 0", flags, pattern_cnt);
    end
    total++;
    if (flags0 !== 7'b0 || pattern_cnt0 !== 16'd0) begin
      bad++; $display("FAIL reset_dut0 flags=%b cnt=%0d want 0", flags0, pattern_cnt0);
    end
  endtask

  task automatic test_pass_run;
    logic [6:0]  exp;
    logic [15:0] exp_cnt;
    logic        en, bz, dn;
    int          en_cycles = 0;
    misr = 4'hA;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 18; k++) begin
      if (k > 0) tick();
      en = (k >= 1 && k <= 15);
      bz = (k <= 17);
      dn = (k == 18);
      exp = {k == 0, en, en, bz, dn, dn, 1'b0};
      exp_cnt = (k == 0) ? 16'd0 : (k <= 16) ? 16'(k - 1) : 16'd15;
      if (lfsr_en) en_cycles++;
      total++;
      if (flags !== exp || pattern_cnt !== exp_cnt) begin
        bad++;
        $display("FAIL pass_run edge=%0d flags=%b cnt=%0d want flags=%b cnt=%0d",
                 k, flags, pattern_cnt, exp, exp_cnt);
      end
    end
    total++;
    if (en_cycles != 15) begin
      bad++; $display("FAIL pass_run_en_len got=%0d want=15", en_cycles);
    end
    repeat (3) tick();
    total++;
    if (flags !== 7'b0000110 || pattern_cnt !== 16'd15) begin
      bad++; $display("FAIL pass_run_hold flags=%b cnt=%0d want 0000110 cnt=15", flags, pattern_cnt);
    end
  endtask

  task automatic test_fail_run;
    misr = 4'h5;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (flags !== 7'b1001000 || pattern_cnt !== 16'd0) begin
      bad++; $display("FAIL fail_run_load flags=%b cnt=%0d want 1001000 cnt=0", flags, pattern_cnt);
    end
    repeat (17) tick();
    total++;
    if (flags !== 7'b0001000) begin
      bad++; $display("FAIL fail_run_compare flags=%b want 0001000", flags);
    end
    tick();
    total++;
    if (flags !== 7'b0000101 || pattern_cnt !== 16'd15) begin
      bad++; $display("FAIL fail_run_done flags=%b cnt=%0d want 0000101 cnt=15", flags, pattern_cnt);
    end
`ifdef BIST_SIG_CAPTURE_EN
    total++;
    if (sig_out !== 4'h5) begin
      bad++; $display("FAIL fail_run_sig got=%h want=5", sig_out);
    end
`endif
  endtask

  task automatic test_abort;
    misr = 4'hA;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    total++;
    if (flags !== 7'b0111000 || pattern_cnt !== 16'd6) begin
      bad++; $display("FAIL abort_pre flags=%b cnt=%0d want 0111000 cnt=6", flags, pattern_cnt);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (flags !== 7'b0 || pattern_cnt !== 16'd7) begin
      bad++; $display("FAIL abort_idle flags=%b cnt=%0d want 0 cnt=7", flags, pattern_cnt);
    end
`ifdef BIST_SIG_CAPTURE_EN
    total++;
    if (sig_out !== 4'h5) begin
      bad++; $display("FAIL abort_sig_hold got=%h want=5", sig_out);
    end
`endif
    tick();
    total++;
    if (flags !== 7'b0 || pattern_cnt !== 16'd7) begin
      bad++; $display("FAIL abort_stay flags=%b cnt=%0d want 0 cnt=7", flags, pattern_cnt);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (17) tick();
    total++;
    if (flags !== 7'b0001000) begin
      bad++; $display("FAIL abort_rerun_early flags=%b want 0001000", flags);
    end
    tick();
    total++;
    if (flags !== 7'b0000110 || pattern_cnt !== 16'd15) begin
      bad++; $display("FAIL abort_rerun_done flags=%b cnt=%0d want 0000110 cnt=15", flags, pattern_cnt);
    end
  endtask

  task automatic test_zero_patterns;
    logic [6:0] exp;
    for (int r = 0; r < 2; r++) begin
      misr = (r == 0) ? 4'hA : 4'h3;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int k = 0; k <= 3; k++) begin
        if (k > 0) tick();
        case (k)
          0:       exp = 7'b1001000;
          1, 2:    exp = 7'b0001000;
          default: exp = (r == 0) ? 7'b0000110 : 7'b0000101;
        endcase
        total++;
        if (flags0 !== exp || pattern_cnt0 !== 16'd0) begin
          bad++;
          $display("FAIL zero_run r=%0d edge=%0d flags=%b cnt=%0d want flags=%b cnt=0",
                   r, k, flags0, pattern_cnt0, exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] exp;
    misr = 4'hA;
    start = 1'b1;
    tick();
    for (int k = 1; k <= 37; k++) begin
      tick();
      case (k)
        17:      exp = 7'b0001000;
        18:      exp = 7'b0000110;
        19:      exp = 7'b1001000;
        20:      exp = 7'b0111000;
        36:      exp = 7'b0001000;
        37:      exp = 7'b0000110;
        default: exp = flags;
      endcase
      if (k == 17 || k == 18 || k == 19 || k == 20 || k == 36 || k == 37) begin
        total++;
        if (flags !== exp) begin
          bad++; $display("FAIL back_to_back edge=%0d flags=%b want=%b", k, flags, exp);
        end
      end
    end
    total++;
    if (pattern_cnt !== 16'd15) begin
      bad++; $display("FAIL back_to_back_cnt got=%0d want=15", pattern_cnt);
    end
    start = 1'b0;
    tick();
    total++;
    if (flags !== 7'b0000110) begin
      bad++; $display("FAIL back_to_back_hold flags=%b want 0000110", flags);
    end
  endtask

  task automatic test_collision;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (flags !== 7'b0) begin
      bad++; $display("FAIL abort_from_done flags=%b want 0", flags);
    end
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    total++;
    if (flags !== 7'b0) begin
      bad++; $display("FAIL start_abort_collide flags=%b want 0", flags);
    end
    tick();
    total++;
    if (flags !== 7'b0) begin
      bad++; $display("FAIL collide_stay flags=%b want 0", flags);
    end
  endtask

  task automatic test_async_reset;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    total++;
    if (flags !== 7'b0111000) begin
      bad++; $display("FAIL async_pre flags=%b want 0111000", flags);
    end
    #2 resetn = 1'b0;
    #1;
    total++;
    if (flags !== 7'b0 || pattern_cnt !== 16'd0) begin
      bad++; $display("FAIL async_reset flags=%b cnt=%0d want 0 cnt=0", flags, pattern_cnt);
    end
`ifdef BIST_SIG_CAPTURE_EN
    total++;
    if (sig_out !== 4'h0) begin
      bad++; $display("FAIL async_reset_sig got=%h want=0", sig_out);
    end
`endif
    @(posedge clk); #2 resetn = 1'b1;
    tick();
    total++;
    if (flags !== 7'b0) begin
      bad++; $display("FAIL async_release flags=%b want 0", flags);
    end
  endtask

  initial begin
    test_reset();
    test_pass_run();
    test_fail_run();
    test_abort();
    test_zero_patterns();
    test_back_to_back();
    test_collision();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
